// File: rtl/host_line_loader.sv
// host_line_loader: buffers host bytes in a FIFO and streams them to the MCU one full line at a time.
// Build option LOADER_WATCHDOG_EN adds a WAIT_DONE timeout (WD_CYCLES) with a sticky wd_timeout output.
module host_line_loader #(
    parameter int LINE_BYTES = 64,
    parameter int FIFO_DEPTH = 128,
    parameter int CNT_W      = 16
`ifdef LOADER_WATCHDOG_EN
    ,
    parameter int WD_CYCLES  = 1024
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    host_byte,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic                          mcu_done_flag,
    output logic [7:0]                    host_input,
    output logic                          line_read_from_host_en,
    output logic                          line_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              lines_loaded
`ifdef LOADER_WATCHDOG_EN
    ,
    output logic                          wd_timeout
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(LINE_BYTES) + 1;

    typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_DONE} state_t;

    state_t           state_reg;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_addr;
    logic [CW-1:0]    count_reg;
    logic [BW-1:0]    beat_reg;
    logic             done_q_reg;
    logic [7:0]       host_input_reg;
    logic             en_reg;
    logic             busy_reg;
    logic [CNT_W-1:0] lines_reg;
    logic             push;
    logic             pop;
    logic             done_edge;

`ifdef LOADER_WATCHDOG_EN
    localparam int WW = $clog2(WD_CYCLES) + 1;
    logic [WW-1:0]    wd_cnt_reg;
    logic             wd_timeout_reg;
    assign wd_timeout = wd_timeout_reg;
`endif

    assign host_ready = (count_reg < CW'(FIFO_DEPTH)) && !rst;
    assign push       = host_valid && host_ready;
    assign pop        = (state_reg == START) || (state_reg == STREAM);
    assign done_edge  = mcu_done_flag && !done_q_reg;

    // Read address looks one pop ahead so the registered read lands on the byte shown next cycle.
    assign rd_addr = rd_ptr_reg + AW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= host_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            beat_reg       <= '0;
            done_q_reg     <= 1'b0;
            host_input_reg <= '0;
            en_reg         <= 1'b0;
            busy_reg       <= 1'b0;
            lines_reg      <= '0;
`ifdef LOADER_WATCHDOG_EN
            wd_cnt_reg     <= '0;
            wd_timeout_reg <= 1'b0;
`endif
        end else begin
`ifdef LOADER_WATCHDOG_EN
            wd_cnt_reg <= '0;
`endif
            case (state_reg)
                IDLE: begin
                    done_q_reg <= 1'b0;
                    if (count_reg >= CW'(LINE_BYTES)) begin
                        state_reg      <= START;
                        en_reg         <= 1'b1;
                        busy_reg       <= 1'b1;
                        host_input_reg <= mem[rd_addr];
                    end
                end
                START: begin
                    state_reg      <= STREAM;
                    en_reg         <= 1'b0;
                    beat_reg       <= BW'(1);
                    done_q_reg     <= mcu_done_flag;
                    host_input_reg <= mem[rd_addr];
                end
                STREAM: begin
                    // Tracking the flag here keeps a level left high from the last line from looking like a new edge.
                    done_q_reg <= mcu_done_flag;
                    if (beat_reg == BW'(LINE_BYTES - 1)) begin
                        state_reg      <= WAIT_DONE;
                        host_input_reg <= '0;
                    end else begin
                        beat_reg       <= beat_reg + BW'(1);
                        host_input_reg <= mem[rd_addr];
                    end
                end
                WAIT_DONE: begin
                    done_q_reg <= mcu_done_flag;
                    if (done_edge) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        lines_reg <= lines_reg + CNT_W'(1);
                    end
`ifdef LOADER_WATCHDOG_EN
                    else if (wd_cnt_reg == WW'(WD_CYCLES - 1)) begin
                        state_reg      <= IDLE;
                        busy_reg       <= 1'b0;
                        wd_timeout_reg <= 1'b1;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + WW'(1);
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign host_input             = host_input_reg;
    assign line_read_from_host_en = en_reg;
    assign line_busy              = busy_reg;
    assign fifo_count             = count_reg;
    assign lines_loaded           = lines_reg;

endmodule
